// File: rtl/mlp_seq_engine_if.sv
// Host weight-load port, input activation stream and output result stream of mlp_seq_engine.
interface mlp_seq_engine_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
);
   logic              wt_we;
   logic [ADDR_W-1:0] wt_addr;
   logic [DATA_W-1:0] wt_wdata;
   logic              wt_drop;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;
   logic              sat;

   modport slave (
      input  wt_we, wt_addr, wt_wdata, in_valid, in_data, out_ready,
      output wt_drop, in_ready, out_valid, out_data, out_last, busy, sat
   );

   modport master (
      output wt_we, wt_addr, wt_wdata, in_valid, in_data, out_ready,
      input  wt_drop, in_ready, out_valid, out_data, out_last, busy, sat
   );
endinterface

// File: rtl/mlp_seq_engine.sv
// Sequential MLP: NUM_LAYERS dense DIMxDIM layers on one shared MAC, ping-pong activation
// buffers, per-neuron bias/round/saturate/ReLU, stream input and output.
module mlp_seq_engine #(
   parameter int DATA_W     = 16,
   parameter int FRAC_BITS  = 8,
   parameter int ACC_W      = 40,
   parameter int DIM        = 4,
   parameter int NUM_LAYERS = 2,
   parameter int RELU_LAST  = 0
) (
   input logic             clk,
   input logic             reset,
   mlp_seq_engine_if.slave bus
);
   localparam int WDEPTH = NUM_LAYERS * DIM * (DIM + 1);
   localparam int AW     = (WDEPTH > 1) ? $clog2(WDEPTH) : 1;
   localparam int IW     = (DIM > 1) ? $clog2(DIM) : 1;
   localparam int LW     = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam logic [IW-1:0] LAST_I   = IW'(DIM - 1);
   localparam logic [LW-1:0] LAST_L   = LW'(NUM_LAYERS - 1);
   localparam logic [AW:0]   WDEPTH_L = (AW + 1)'(WDEPTH);
   localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

   typedef enum logic [2:0] {IDLE, LOAD, MAC, FIN, OUT} state_t;

   state_t state_reg, state_next;

   logic signed [DATA_W-1:0] wmem  [WDEPTH];
   logic signed [DATA_W-1:0] buf_a [DIM];
   logic signed [DATA_W-1:0] buf_b [DIM];

   logic [IW-1:0]           idx_reg, i_reg, o_reg;
   logic [LW-1:0]           layer_reg;
   logic [AW-1:0]           wptr_reg;
   logic signed [ACC_W-1:0] acc_reg;
   logic                    sel_reg;
   logic                    sat_reg, in_ready_reg, wt_drop_reg;
   logic                    out_valid_reg, out_last_reg;
   logic [DATA_W-1:0]       out_data_reg;

   logic                      busy, in_range, wt_write, accept, out_fire, start_mac;
   logic [IW-1:0]             ld_idx, idx_inc;
   logic signed [DATA_W-1:0]  w_val, src_val, res, fin_cur, fin_nxt;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]   prod_ext, bias_ext, biased, shifted;
   logic                      clip_hi, clip_lo, relu_en;

   assign busy     = (state_reg != IDLE);
   assign in_range = ({1'b0, bus.wt_addr} < WDEPTH_L);
   assign wt_write = bus.wt_we & ~busy & in_range;
   assign accept   = bus.in_valid & in_ready_reg;
   assign out_fire = out_valid_reg & bus.out_ready;
   assign ld_idx   = (state_reg == LOAD) ? idx_reg : '0;
   assign idx_inc  = idx_reg + 1'b1;

   // The weight pointer walks the memory in storage order: DIM weights then the bias per neuron.
   assign w_val    = wmem[wptr_reg];
   assign src_val  = sel_reg ? buf_b[i_reg] : buf_a[i_reg];
   assign prod     = src_val * w_val;
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   assign bias_ext = {{(ACC_W-DATA_W){w_val[DATA_W-1]}}, w_val};
   assign biased   = acc_reg + (bias_ext <<< FRAC_BITS);
   assign shifted  = biased >>> FRAC_BITS;
   assign clip_hi  = (shifted > MAX_V);
   assign clip_lo  = (shifted < MIN_V);
   assign relu_en  = (layer_reg != LAST_L) || (RELU_LAST != 0);

   always_comb begin
      res = clip_hi ? MAX_V[DATA_W-1:0] : (clip_lo ? MIN_V[DATA_W-1:0] : shifted[DATA_W-1:0]);
      if (relu_en && res[DATA_W-1]) res = '0;
   end

   // The final layer wrote the buffer opposite to its source.
   assign fin_cur = sel_reg ? buf_a[idx_reg] : buf_b[idx_reg];
   assign fin_nxt = sel_reg ? buf_a[idx_inc] : buf_b[idx_inc];

   always_comb begin
      state_next = state_reg;
      start_mac  = 1'b0;
      case (state_reg)
         IDLE: if (accept) begin
            state_next = (DIM == 1) ? MAC : LOAD;
            start_mac  = (DIM == 1);
         end
         LOAD: if (accept && idx_reg == LAST_I) begin
            state_next = MAC;
            start_mac  = 1'b1;
         end
         MAC:  if (i_reg == LAST_I) state_next = FIN;
         FIN:  state_next = (o_reg == LAST_I && layer_reg == LAST_L) ? OUT : MAC;
         OUT:  if (out_fire && out_last_reg) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         idx_reg       <= '0;
         i_reg         <= '0;
         o_reg         <= '0;
         layer_reg     <= '0;
         wptr_reg      <= '0;
         acc_reg       <= '0;
         sel_reg       <= 1'b0;
         sat_reg       <= 1'b0;
         in_ready_reg  <= 1'b0;
         wt_drop_reg   <= 1'b0;
         out_valid_reg <= 1'b0;
         out_last_reg  <= 1'b0;
         out_data_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next == IDLE) || (state_next == LOAD);
         wt_drop_reg  <= bus.wt_we & busy & in_range;
         case (state_reg)
            IDLE: if (accept) begin
               sat_reg <= 1'b0;
               idx_reg <= IW'(1);
            end
            LOAD: if (accept) idx_reg <= idx_inc;
            MAC: begin
               acc_reg  <= acc_reg + prod_ext;
               wptr_reg <= wptr_reg + 1'b1;
               i_reg    <= (i_reg == LAST_I) ? '0 : i_reg + 1'b1;
            end
            FIN: begin
               acc_reg  <= '0;
               wptr_reg <= wptr_reg + 1'b1;
               if (clip_hi || clip_lo) sat_reg <= 1'b1;
               if (o_reg != LAST_I) begin
                  o_reg <= o_reg + 1'b1;
               end else begin
                  o_reg <= '0;
                  if (layer_reg != LAST_L) begin
                     layer_reg <= layer_reg + 1'b1;
                     sel_reg   <= ~sel_reg;
                  end else begin
                     idx_reg       <= '0;
                     out_valid_reg <= 1'b0;
                  end
               end
            end
            OUT: begin
               // First OUT cycle fetches beat 0; later beats are fetched on each handshake.
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= fin_cur;
                  out_last_reg  <= (idx_reg == LAST_I);
               end else if (out_fire) begin
                  if (out_last_reg) begin
                     out_valid_reg <= 1'b0;
                     out_last_reg  <= 1'b0;
                     out_data_reg  <= '0;
                  end else begin
                     idx_reg      <= idx_inc;
                     out_data_reg <= fin_nxt;
                     out_last_reg <= (idx_inc == LAST_I);
                  end
               end
            end
            default: ;
         endcase
         if (start_mac) begin
            i_reg     <= '0;
            o_reg     <= '0;
            layer_reg <= '0;
            wptr_reg  <= '0;
            acc_reg   <= '0;
            sel_reg   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wt_write) wmem[bus.wt_addr] <= bus.wt_wdata;
      if (accept) buf_a[ld_idx] <= bus.in_data;
      if (state_reg == FIN) begin
         if (sel_reg) buf_a[o_reg] <= res;
         else         buf_b[o_reg] <= res;
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.busy      = busy;
   assign bus.sat       = sat_reg;
   assign bus.wt_drop   = wt_drop_reg;
endmodule

// File: doc/mlp_seq_engine.md
Name: mlp_seq_engine

Overview:
- Parametrised, sequential multi-layer perceptron engine: NUM_LAYERS dense layers of DIM×DIM signed fixed-point weights plus bias, computed with one shared MAC.
- Sits between the feature front end (input stream) and the classifier/readout logic (output stream).
- Weights and biases are host-loaded through a write port into internal storage.
- Supersedes the single-layer-at-a-time MLP controller with real datapath, ping-pong activation buffers, per-layer ReLU, saturation and stream handshakes.

Parameters:
DATA_W, 16, signed activation/weight/bias width (two's complement fixed point)
FRAC_BITS, 8, fractional bits of DATA_W values (default Q8.8)
ACC_W, 40, accumulator width, must be >= 2*DATA_W + clog2(DIM) + 1
DIM, 4, neurons per layer and input vector length
NUM_LAYERS, 2, number of dense layers, >= 1
RELU_LAST, 0, 1 = apply ReLU to final layer too (hidden layers always ReLU)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wt_we  in  1  weight/bias write strobe
wt_addr  in  clog2(NUM_LAYERS*DIM*(DIM+1))  word address: l*DIM*(DIM+1) + o*(DIM+1) + i; i=DIM selects bias of neuron o
wt_wdata  in  DATA_W  write data
wt_drop  out  1  one-cycle pulse: write ignored because busy
in_valid  in  1  input beat valid
in_ready  out  1  engine accepts input
in_data  in  DATA_W  input element, element 0 first
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  output element, neuron 0 first
out_last  out  1  marks neuron DIM-1 beat
busy  out  1  high in every state except IDLE
sat  out  1  sticky: any neuron saturated in current inference; cleared at first accepted input beat

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, sat=0, wt_drop=0; state IDLE; all counters 0. Weight memory and activation buffers are not reset; they keep their contents.
- States: IDLE -> LOAD -> MAC -> FIN -> (MAC | next layer MAC | OUT) -> IDLE.
- IDLE: in_ready=1. Accepted beat (in_valid & in_ready) writes buf A[0], clears sat, goes to LOAD with idx=1. DIM=1 goes straight to MAC.
- LOAD: in_ready=1. Each accepted beat writes buf A[idx] and increments idx. The beat with idx=DIM-1 goes to MAC with layer=0, o=0, i=0, acc=0. in_ready=0 in all other states.
- MAC: one cycle per i, acc += src[i]*W[layer][o][i]. Full-precision signed product, sign-extended to ACC_W. Weight read is combinational. After i=DIM-1, go to FIN.
- FIN (1 cycle):
  - r = (acc + (bias sign-extended << FRAC_BITS)) >>> FRAC_BITS, arithmetic shift (floor).
  - Saturate r to DATA_W signed range; set sat if clipped.
  - Apply ReLU (negative -> 0) if layer < NUM_LAYERS-1 or RELU_LAST=1.
  - Write r to dst[o]. Then:
    - o < DIM-1: o++, go to MAC.
    - else if layer < NUM_LAYERS-1: layer++, swap src/dst, o=0, go to MAC.
    - else go to OUT with idx=0.
- Compute latency: DIM*(DIM+1) cycles per layer. out_valid first rises exactly NUM_LAYERS*DIM*(DIM+1)+1 cycles after the clock edge accepting the last input beat.
- OUT:
  - out_valid=1, out_data=final buffer[idx], out_last=(idx==DIM-1).
  - out_data/out_last are held stable while out_valid & !out_ready.
  - On handshake idx++. Handshake with out_last goes to IDLE; in_ready is 1 on the next cycle.
- Weight port:
  - wt_we & !busy writes the word on that edge.
  - wt_we & busy is ignored and pulses wt_drop the next cycle.
  - Out-of-range address is ignored without wt_drop.
  - A write in the same cycle as the first input beat is accepted (busy still 0).
- Reset asserted mid-operation: return to IDLE on assertion. No output beat is emitted after deassertion until a full new input vector is accepted. Weights are preserved.
- No input is accepted while computing or outputting (no overlap between inferences).

Test Plan:
- Identity: DIM=4, NUM_LAYERS=2, all W = I (0x0100 diagonal), bias 0; input 1.0, 2.0, 3.0, 4.0 (0x0100..0x0400) -> outputs 0x0100, 0x0200, 0x0300, 0x0400; out_last on 4th beat; out_valid rises exactly 41 cycles after last input edge.
- Bias+ReLU: layer0 W=I, bias -2.5 (0xFD80); layer1 W=I, bias 0; RELU_LAST=0; input 1,2,3,4 -> 0x0000, 0x0000, 0x0080, 0x0180.
- Saturation: all W=0x7FFF, input all 0x7FFF -> layer0 clips to 0x7FFF, sat=1, final outputs 0x7FFF. Next inference with W=I clears sat to 0.
- Backpressure: identity setup, out_ready toggling 1,0,0,1,0,1,1 -> four beats in order, data stable during stalls, exactly one out_last.
- Write-while-busy: wt_we pulse during MAC -> wt_drop=1 for one cycle, outputs identical to the identity case. Same write in IDLE -> takes effect on the next inference.
- Reset mid-MAC: assert reset in layer1 -> all outputs at reset values; after release, send a new vector -> correct results using retained weights.
